sprite_overlay_engine: RTL and testbench

- Parametrised sprite compositor that replaces fixed, hard-coded character drawing.
- Holds NUM_SPRITES 16x16 monochrome sprites. Position, enable, flip and colour are software-writable over the Avalon slave.
- Commits new positions atomically at the start of vertical blanking, overlays sprites on the tile-layer colour, and reports sprite-0 collisions.
- Sits between the tile renderer / vga_counters and the VGA colour pins.

---
 rtl/sprite_overlay_engine.sv | 198 +++++++++++++++++++
 tb/tb_sprite_overlay_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_overlay_engine.sv
// Sprite compositor: NUM_SPRITES 16x16 monochrome sprites overlaid on the tile-layer colour,
// with Avalon register access, vblank-synchronised position commit and sprite-0 collision flags.
module sprite_overlay_engine #(
   parameter int NUM_SPRITES = 4,
   parameter int COORD_W     = 10,
   parameter int VACTIVE     = 480,
   parameter int HACTIVE_PIX = 640
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [2:0]  address,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   input  logic [10:0] hcount,
   input  logic [9:0]  vcount,
   input  logic [7:0]  bg_r,
   input  logic [7:0]  bg_g,
   input  logic [7:0]  bg_b,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B
);

   localparam int CW1 = COORD_W + 1;

   logic [7:0]         sel_reg;
   logic [3:0]         sel_idx;
   logic [3:0]         sel_row;
   logic [7:0]         frame_reg;
   logic               wr, rd, commit, vblank, active_c;
   logic [CW1-1:0]     px_w, py_w;

   logic [COORD_W-1:0] x_pend_reg [NUM_SPRITES];
   logic [COORD_W-1:0] y_pend_reg [NUM_SPRITES];
   logic [1:0]         ctrl_pend_reg [NUM_SPRITES];
   logic [15:0]        col_pend_reg [NUM_SPRITES];
   logic [COORD_W-1:0] x_act_reg [NUM_SPRITES];
   logic [COORD_W-1:0] y_act_reg [NUM_SPRITES];
   logic [1:0]         ctrl_act_reg [NUM_SPRITES];
   logic [15:0]        col_act_reg [NUM_SPRITES];

   logic [NUM_SPRITES-1:0] hit_c, coll_set, coll_reg, coll_next;
   logic [NUM_SPRITES-1:0] hit_s1_reg;
   logic [15:0]            col_s1_reg [NUM_SPRITES];
   logic [23:0]            bg_s1_reg;
   logic                   active_s1_reg;
   logic [15:0]            readdata_next, pick_col;
   logic [23:0]            rgb_next;

   assign sel_idx  = sel_reg[7:4];
   assign sel_row  = sel_reg[3:0];
   assign wr       = chipselect & write;
   assign rd       = chipselect & read;
   assign commit   = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
   assign vblank   = (vcount >= 10'(VACTIVE));
   assign active_c = (hcount < 11'(2 * HACTIVE_PIX)) && (vcount < 10'(VACTIVE));
   assign px_w     = CW1'(hcount[10:1]);
   assign py_w     = CW1'(vcount);

   always_ff @(posedge clk) begin
      if (reset) begin
         sel_reg   <= '0;
         frame_reg <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            x_pend_reg[i]    <= '0;
            y_pend_reg[i]    <= '0;
            ctrl_pend_reg[i] <= '0;
            col_pend_reg[i]  <= '0;
            x_act_reg[i]     <= '0;
            y_act_reg[i]     <= '0;
            ctrl_act_reg[i]  <= '0;
            col_act_reg[i]   <= '0;
         end
      end else begin
         if (wr && address == 3'd0)
            sel_reg <= writedata[7:0];
         else if (wr && address == 3'd5)
            sel_reg[3:0] <= sel_row + 4'd1;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (wr && sel_idx == 4'(i)) begin
               case (address)
                  3'd1: x_pend_reg[i]    <= writedata[COORD_W-1:0];
                  3'd2: y_pend_reg[i]    <= writedata[COORD_W-1:0];
                  3'd3: ctrl_pend_reg[i] <= writedata[1:0];
                  3'd4: col_pend_reg[i]  <= writedata;
                  default: ;
               endcase
            end
         end
         // Active set takes the pre-write pending value when a write lands on the commit cycle.
         if (commit) begin
            frame_reg <= frame_reg + 8'd1;
            for (int i = 0; i < NUM_SPRITES; i++) begin
               x_act_reg[i]    <= x_pend_reg[i];
               y_act_reg[i]    <= y_pend_reg[i];
               ctrl_act_reg[i] <= ctrl_pend_reg[i];
               col_act_reg[i]  <= col_pend_reg[i];
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SPRITES; gi++) begin : gen_sprite
         logic [15:0]    bmp_mem [16];
         logic [CW1-1:0] x_w, y_w;
         logic [3:0]     col, row;
         logic [15:0]    row_data;
         logic           in_x, in_y, pix_bit;

         always_ff @(posedge clk) begin
            if (wr && address == 3'd5 && sel_idx == 4'(gi))
               bmp_mem[sel_row] <= writedata;
         end

         // Widened compare keeps X+16 from wrapping near the right edge.
         assign x_w      = CW1'(x_act_reg[gi]);
         assign y_w      = CW1'(y_act_reg[gi]);
         assign in_x     = (px_w >= x_w) && (px_w < x_w + CW1'(16));
         assign in_y     = (py_w >= y_w) && (py_w < y_w + CW1'(16));
         assign col      = px_w[3:0] - x_w[3:0];
         assign row      = py_w[3:0] - y_w[3:0];
         assign row_data = bmp_mem[row];
         assign pix_bit  = ctrl_act_reg[gi][1] ? row_data[col] : row_data[4'd15 - col];
         assign hit_c[gi] = ctrl_act_reg[gi][0] & in_x & in_y & pix_bit;
      end
   endgenerate

   always_comb begin
      coll_set = '0;
      for (int i = 1; i < NUM_SPRITES; i++)
         coll_set[i] = active_c & hit_c[0] & hit_c[i];
      // A new overlap in the same cycle as a clearing read keeps its bit.
      coll_next = ((rd && address == 3'd7) ? '0 : coll_reg) | coll_set;
   end

   always_comb begin
      readdata_next = '0;
      if (rd) begin
         case (address)
            3'd0: readdata_next = {8'h00, sel_reg};
            3'd6: readdata_next = {frame_reg, 7'd0, vblank};
            3'd7: readdata_next = 16'(coll_reg);
            default: begin
               for (int i = 0; i < NUM_SPRITES; i++) begin
                  if (sel_idx == 4'(i)) begin
                     case (address)
                        3'd1: readdata_next = 16'(x_pend_reg[i]);
                        3'd2: readdata_next = 16'(y_pend_reg[i]);
                        3'd3: readdata_next = {14'd0, ctrl_pend_reg[i]};
                        3'd4: readdata_next = col_pend_reg[i];
                        default: ;
                     endcase
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      pick_col = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--)
         if (hit_s1_reg[i]) pick_col = col_s1_reg[i];
      if (!active_s1_reg)
         rgb_next = '0;
      else if (|hit_s1_reg)
         rgb_next = {pick_col[15:11], pick_col[15:13], pick_col[10:5], pick_col[10:9],
                     pick_col[4:0], pick_col[4:2]};
      else
         rgb_next = bg_s1_reg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         coll_reg      <= '0;
         readdata      <= '0;
         hit_s1_reg    <= '0;
         bg_s1_reg     <= '0;
         active_s1_reg <= 1'b0;
         {VGA_R, VGA_G, VGA_B} <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) col_s1_reg[i] <= '0;
      end else begin
         coll_reg      <= coll_next;
         readdata      <= readdata_next;
         hit_s1_reg    <= hit_c;
         bg_s1_reg     <= {bg_r, bg_g, bg_b};
         active_s1_reg <= active_c;
         {VGA_R, VGA_G, VGA_B} <= rgb_next;
         for (int i = 0; i < NUM_SPRITES; i++) col_s1_reg[i] <= col_act_reg[i];
      end
   end

endmodule

// File: tb/tb_sprite_overlay_engine.sv
// Self-checking bench for sprite_overlay_engine: pixel vectors go through a scoreboard queue,
// register and reset corner cases are checked by hand-written sequences.
module tb_sprite_overlay_engine;

   logic        clk = 1'b0;
   logic        reset, chipselect, write, read;
   logic [2:0]  address;
   logic [15:0] writedata, readdata;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [7:0]  bg_r, bg_g, bg_b, VGA_R, VGA_G, VGA_B;

   sprite_overlay_engine #(.NUM_SPRITES(4), .COORD_W(10), .VACTIVE(480), .HACTIVE_PIX(640)) dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
      .address(address), .writedata(writedata), .readdata(readdata),
      .hcount(hcount), .vcount(vcount), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );

   always #5 clk = ~clk;

   localparam logic [23:0] RED   = 24'hFF0000;
   localparam logic [23:0] GREEN = 24'h00FF00;
   localparam logic [23:0] BLUE  = 24'h0000FF;
   localparam logic [23:0] GREY  = 24'h848284;

   typedef struct {
      int          px;
      int          py;
      logic [23:0] bg;
      logic [23:0] exp;
      string       name;
   } vec_t;

   vec_t        vecs[$];
   logic [23:0] exp_q[$];
   string       name_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          frames = 0;
   logic        drive_valid = 1'b0;
   logic        v1 = 1'b0, v2 = 1'b0;

   // Tags a driven pixel so its expected value is popped exactly two clocks later.
   always @(posedge clk) begin
      v1 <= drive_valid;
      v2 <= v1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      logic [23:0] e;
      string       nm;
      @(negedge clk);
      if (v2) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got pixel %h expected none", {VGA_R, VGA_G, VGA_B});
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, e});
         end
      end
   endtask

   task automatic idle_pix();
      drive_valid = 1'b0;
      hcount = 11'd1300;
      vcount = 10'd0;
      {bg_r, bg_g, bg_b} = 24'h5A5A5A;
   endtask

   task automatic add(input int px, input int py, input logic [23:0] bg, input logic [23:0] exp,
                      input string nm);
      vec_t v;
      v.px = px; v.py = py; v.bg = bg; v.exp = exp; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic run_vecs();
      foreach (vecs[i]) begin
         hcount = 11'(vecs[i].px * 2);
         vcount = 10'(vecs[i].py);
         {bg_r, bg_g, bg_b} = vecs[i].bg;
         drive_valid = 1'b1;
         exp_q.push_back(vecs[i].exp);
         name_q.push_back(vecs[i].name);
         tick();
      end
      idle_pix();
      repeat (3) tick();
      chk("sb_drained", exp_q.size(), 0);
      vecs.delete();
   endtask

   task automatic av_write(input logic [2:0] a, input logic [15:0] d);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic av_read(input logic [2:0] a, input logic [15:0] exp, input string nm);
      chipselect = 1'b1; read = 1'b1; address = a;
      tick();
      chk(nm, readdata, exp);
      chipselect = 1'b0; read = 1'b0;
   endtask

   task automatic commit();
      drive_valid = 1'b0;
      hcount = 11'd0;
      vcount = 10'd480;
      tick();
      frames = (frames + 1) % 256;
      idle_pix();
   endtask

   task automatic load_sprite(input logic [7:0] sel, input logic [15:0] row0, input logic [15:0] rest,
                              input int x, input int y, input logic [15:0] col, input logic [1:0] ctrl);
      av_write(3'd0, {8'h00, sel});
      av_write(3'd5, row0);
      for (int r = 1; r < 16; r++) av_write(3'd5, rest);
      av_write(3'd1, 16'(x));
      av_write(3'd2, 16'(y));
      av_write(3'd4, col);
      av_write(3'd3, {14'd0, ctrl});
   endtask

   initial begin
      reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
      address = 3'd0; writedata = 16'd0;
      idle_pix();
      repeat (3) tick();
      chk("rst_vga", {8'h00, VGA_R, VGA_G, VGA_B}, 32'd0);
      chk("rst_readdata", readdata, 0);
      reset = 1'b0;
      tick();
      av_read(3'd6, 16'h0000, "status_after_rst");
      av_read(3'd7, 16'h0000, "coll_after_rst");

      // Sprite 1: solid block, row pointer wraps back to 0 after 16 BMP writes
      load_sprite(8'h10, 16'hFFFF, 16'hFFFF, 100, 50, 16'hF800, 2'b01);
      av_read(3'd0, 16'h0010, "sel_row_wrap");
      av_read(3'd1, 16'd100, "x_readback");
      add(100, 50, 24'h102030, 24'h102030, "precommit_bg");
      run_vecs();
      commit();
      av_read(3'd6, {8'(frames), 8'h00}, "frame_after_commit");
      add(100, 50, 24'h111111, RED,        "s1_topleft");
      add(116, 50, 24'h222222, 24'h222222, "s1_right_edge_bg");
      add(115, 65, 24'h333333, RED,        "s1_botright");
      add(99, 50,  24'h444444, 24'h444444, "s1_left_bg");
      add(107, 58, 24'h555555, RED,        "s1_middle");
      add(100, 66, 24'h666666, 24'h666666, "s1_below_bg");
      add(100, 49, 24'h777777, 24'h777777, "s1_above_bg");
      add(700, 50, 24'h888888, 24'h000000, "hblank_zero");
      add(100, 480, 24'h999999, 24'h000000, "vblank_zero");
      run_vecs();

      // Pending X only reaches the screen at the commit point
      av_write(3'd1, 16'd200);
      add(100, 50, 24'h010101, RED,        "x_pending_old");
      add(200, 50, 24'h020202, 24'h020202, "x_pending_new_bg");
      run_vecs();
      commit();
      add(200, 50, 24'h030303, RED,        "x_committed_new");
      add(100, 50, 24'h040404, 24'h040404, "x_committed_old_bg");
      run_vecs();
      chipselect = 1'b1; write = 1'b1; address = 3'd1; writedata = 16'd300;
      hcount = 11'd0; vcount = 10'd480;
      tick();
      frames = (frames + 1) % 256;
      chipselect = 1'b0; write = 1'b0;
      idle_pix();
      add(200, 50, 24'h050505, RED,        "commit_cycle_write_old");
      add(300, 50, 24'h060606, 24'h060606, "commit_cycle_write_new_bg");
      run_vecs();
      av_read(3'd1, 16'd300, "commit_cycle_pending");
      commit();
      add(300, 50, 24'h070707, RED,        "next_frame_new");
      add(200, 50, 24'h080808, 24'h080808, "next_frame_old_bg");
      run_vecs();
      hcount = 11'd5; vcount = 10'd480;
      av_read(3'd6, {8'(frames), 8'h01}, "status_vblank");
      idle_pix();
      while (frames != 255) commit();
      av_read(3'd6, 16'hFF00, "frame_255");
      commit();
      av_read(3'd6, 16'h0000, "frame_wrap");

      // Sprites 0 and 2 stacked: priority and collision
      load_sprite(8'h00, 16'hFFFF, 16'hFFFF, 400, 100, 16'h07E0, 2'b01);
      load_sprite(8'h20, 16'hFFFF, 16'hFFFF, 400, 100, 16'h001F, 2'b01);
      commit();
      av_read(3'd7, 16'h0000, "coll_none_yet");
      add(405, 105, 24'h0A0A0A, GREEN,      "prio_s0_mid");
      add(400, 100, 24'h0B0B0B, GREEN,      "prio_s0_corner");
      add(416, 100, 24'h0C0C0C, 24'h0C0C0C, "prio_outside_bg");
      run_vecs();
      av_read(3'd7, 16'h0004, "coll_set");
      av_read(3'd7, 16'h0000, "coll_cleared");
      hcount = 11'd810; vcount = 10'd105;
      chipselect = 1'b1; read = 1'b1; address = 3'd7;
      tick();
      chk("coll_race_read", readdata, 16'h0000);
      chipselect = 1'b0; read = 1'b0;
      idle_pix();
      tick();
      av_read(3'd7, 16'h0004, "coll_race_kept");
      av_write(3'd0, 16'h0000);
      av_write(3'd3, 16'h0000);
      commit();
      add(405, 105, 24'h0D0D0D, BLUE,       "s2_alone");
      run_vecs();
      av_read(3'd7, 16'h0000, "coll_s0_disabled");

      // Sprite 3: single lit pixel, horizontal flip
      load_sprite(8'h30, 16'h8000, 16'h0000, 10, 200, 16'h8410, 2'b11);
      commit();
      add(25, 200, 24'h121212, GREY,       "hflip_lit");
      add(10, 200, 24'h131313, 24'h131313, "hflip_left_bg");
      add(24, 200, 24'h141414, 24'h141414, "hflip_24_bg");
      add(25, 201, 24'h151515, 24'h151515, "hflip_row1_bg");
      run_vecs();
      av_write(3'd3, 16'h0001);
      commit();
      add(10, 200, 24'h161616, GREY,       "noflip_lit");
      add(25, 200, 24'h171717, 24'h171717, "noflip_25_bg");
      add(11, 200, 24'h181818, 24'h181818, "noflip_11_bg");
      run_vecs();

      // Out-of-range sprite index and right-edge clipping
      av_write(3'd0, 16'h0040);
      av_write(3'd1, 16'd123);
      av_write(3'd5, 16'hFFFF);
      av_read(3'd0, 16'h0041, "oob_row_increment");
      av_read(3'd1, 16'h0000, "oob_x_read");
      av_write(3'd0, 16'h0000);
      av_read(3'd1, 16'd400, "oob_s0_x_unchanged");
      av_write(3'd0, 16'h0010);
      av_read(3'd1, 16'd300, "oob_s1_x_unchanged");
      av_write(3'd1, 16'd630);
      commit();
      add(630, 50, 24'h212121, RED,        "clip_630");
      add(639, 50, 24'h222222, RED,        "clip_639");
      add(629, 50, 24'h232323, 24'h232323, "clip_629_bg");
      add(0, 50,   24'h242424, 24'h242424, "clip_nowrap_0");
      add(5, 50,   24'h252525, 24'h252525, "clip_nowrap_5");
      add(640, 50, 24'h262626, 24'h000000, "clip_640_blank");
      run_vecs();

      // Reset in the middle of a visible sprite
      hcount = 11'd1270; vcount = 10'd50; {bg_r, bg_g, bg_b} = 24'hABCDEF;
      tick();
      tick();
      chk("pre_reset_red", {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, RED});
      reset = 1'b1;
      tick();
      chk("midrst_vga", {8'h00, VGA_R, VGA_G, VGA_B}, 32'd0);
      chk("midrst_readdata", readdata, 0);
      reset = 1'b0;
      frames = 0;
      tick();
      chk("midrst_vga_c1", {8'h00, VGA_R, VGA_G, VGA_B}, 32'd0);
      tick();
      chk("midrst_bg_c2", {8'h00, VGA_R, VGA_G, VGA_B}, 32'h00ABCDEF);
      idle_pix();
      av_read(3'd7, 16'h0000, "midrst_coll");
      av_read(3'd6, 16'h0000, "midrst_status");
      av_read(3'd1, 16'h0000, "midrst_x_cleared");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
